// File: rtl/alu_seq_muldiv_if.sv
// Request/result bundle between the EX-stage controller (master) and the ALU (slave).
// Start, ALUControl, A and B are sampled only on an edge where Busy is low; Done pulses for one cycle.
interface alu_seq_muldiv_if #(
  parameter int WIDTH = 32
);
  logic             Start;
  logic [3:0]       ALUControl;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Busy;
  logic             Done;
  logic [WIDTH-1:0] ALUResult;
  logic [WIDTH-1:0] Hi;
  logic             Zero;
  logic             Overflow;
  logic             DivZero;
  logic [1:0]       dbg_state;

  modport master (
    output Start, ALUControl, A, B,
    input  Busy, Done, ALUResult, Hi, Zero, Overflow, DivZero, dbg_state
  );

  modport slave (
    input  Start, ALUControl, A, B,
    output Busy, Done, ALUResult, Hi, Zero, Overflow, DivZero, dbg_state
  );
endinterface

// File: rtl/alu_seq_muldiv.sv
// EX-stage ALU: single-cycle ops finish in one clock; shift-add multiply and restoring
// divide iterate WIDTH times and write the Hi/LO pair, with Done one clock after the last iteration.
module alu_seq_muldiv #(
  parameter int WIDTH = 32
) (
  input  logic              Clk,
  input  logic              Reset,
  alu_seq_muldiv_if.slave   bus
);
  localparam int SHW = $clog2(WIDTH);

  localparam logic [3:0] OP_AND  = 4'd0,  OP_OR   = 4'd1,  OP_ADD  = 4'd2,  OP_NOR  = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4,  OP_MULT = 4'd5,  OP_SUB  = 4'd6,  OP_SLT  = 4'd7;
  localparam logic [3:0] OP_MULU = 4'd8,  OP_DIV  = 4'd9,  OP_SLL  = 4'd10, OP_SGT  = 4'd11;
  localparam logic [3:0] OP_DIVU = 4'd12, OP_ROTR = 4'd13, OP_SLTU = 4'd14;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_FIN = 2'd2} state_t;

  state_t           state_q;
  logic [SHW-1:0]   cnt_q;
  logic             is_div_q, neg_q, rneg_q, bzero_q;
  logic [WIDTH-1:0] a_q, mb_q, acc_q, lo_q;
  logic [WIDTH-1:0] result_q, hi_q;
  logic             busy_q, done_q, zero_q, ovf_q, divz_q;

  // Single-cycle datapath, driven straight from the sampled request.
  logic [WIDTH-1:0]   sum_d, diff_d, alu_d, mag_a, mag_b;
  logic [2*WIDTH-1:0] rot_d;
  logic               ovf_d, is_iter, is_signed;
  logic [SHW-1:0]     sh;

  always_comb begin
    sh        = bus.B[SHW-1:0];
    sum_d     = bus.A + bus.B;
    diff_d    = bus.A - bus.B;
    rot_d     = {bus.A, bus.A} >> sh;
    alu_d     = '0;
    ovf_d     = 1'b0;
    is_iter   = (bus.ALUControl == OP_MULT) || (bus.ALUControl == OP_MULU) ||
                (bus.ALUControl == OP_DIV)  || (bus.ALUControl == OP_DIVU);
    is_signed = (bus.ALUControl == OP_MULT) || (bus.ALUControl == OP_DIV);
    mag_a     = (is_signed && bus.A[WIDTH-1]) ? ('0 - bus.A) : bus.A;
    mag_b     = (is_signed && bus.B[WIDTH-1]) ? ('0 - bus.B) : bus.B;
    case (bus.ALUControl)
      OP_AND:  alu_d = bus.A & bus.B;
      OP_OR:   alu_d = bus.A | bus.B;
      OP_NOR:  alu_d = ~(bus.A | bus.B);
      OP_XOR:  alu_d = bus.A ^ bus.B;
      OP_ADD: begin
        alu_d = sum_d;
        ovf_d = (bus.A[WIDTH-1] == bus.B[WIDTH-1]) && (sum_d[WIDTH-1] != bus.A[WIDTH-1]);
      end
      OP_SUB: begin
        alu_d = diff_d;
        ovf_d = (bus.A[WIDTH-1] != bus.B[WIDTH-1]) && (diff_d[WIDTH-1] != bus.A[WIDTH-1]);
      end
      OP_SLT:  alu_d = {{(WIDTH-1){1'b0}}, ($signed(bus.A) < $signed(bus.B))};
      OP_SGT:  alu_d = {{(WIDTH-1){1'b0}}, ($signed(bus.A) > $signed(bus.B))};
      OP_SLTU: alu_d = {{(WIDTH-1){1'b0}}, (bus.A < bus.B)};
      OP_SLL:  alu_d = bus.A << sh;
      OP_ROTR: alu_d = rot_d[WIDTH-1:0];
      default: alu_d = '0;
    endcase
  end

  // One multiply or divide step, plus the final sign correction applied on the last step.
  logic [WIDTH:0]     add_w, shf_w, sub_w;
  logic [WIDTH-1:0]   acc_nx, lo_nx, fin_res, fin_hi, quot, rem;
  logic [2*WIDTH-1:0] prod;
  logic               fin_divz;

  always_comb begin
    add_w  = lo_q[0] ? ({1'b0, acc_q} + {1'b0, mb_q}) : {1'b0, acc_q};
    shf_w  = {acc_q, lo_q[WIDTH-1]};
    sub_w  = shf_w - {1'b0, mb_q};
    if (is_div_q) begin
      acc_nx = sub_w[WIDTH] ? shf_w[WIDTH-1:0] : sub_w[WIDTH-1:0];
      lo_nx  = {lo_q[WIDTH-2:0], ~sub_w[WIDTH]};
    end else begin
      acc_nx = add_w[WIDTH:1];
      lo_nx  = {add_w[0], lo_q[WIDTH-1:1]};
    end
    prod     = neg_q ? ('0 - {acc_nx, lo_nx}) : {acc_nx, lo_nx};
    quot     = neg_q ? ('0 - lo_nx) : lo_nx;
    rem      = rneg_q ? ('0 - acc_nx) : acc_nx;
    fin_divz = 1'b0;
    if (!is_div_q) begin
      fin_res = prod[WIDTH-1:0];
      fin_hi  = prod[2*WIDTH-1:WIDTH];
    end else if (bzero_q) begin
      fin_res  = '1;
      fin_hi   = a_q;
      fin_divz = 1'b1;
    end else begin
      fin_res = quot;
      fin_hi  = rem;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      is_div_q <= 1'b0;
      neg_q    <= 1'b0;
      rneg_q   <= 1'b0;
      bzero_q  <= 1'b0;
      a_q      <= '0;
      mb_q     <= '0;
      acc_q    <= '0;
      lo_q     <= '0;
      result_q <= '0;
      hi_q     <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      zero_q   <= 1'b0;
      ovf_q    <= 1'b0;
      divz_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        // FIN already shows Busy=0, so a request arriving there is accepted like in IDLE.
        S_IDLE, S_FIN: begin
          state_q <= S_IDLE;
          if (bus.Start) begin
            if (is_iter) begin
              state_q  <= S_RUN;
              busy_q   <= 1'b1;
              cnt_q    <= SHW'(WIDTH - 1);
              is_div_q <= (bus.ALUControl == OP_DIV) || (bus.ALUControl == OP_DIVU);
              neg_q    <= is_signed && (bus.A[WIDTH-1] ^ bus.B[WIDTH-1]);
              rneg_q   <= is_signed && bus.A[WIDTH-1];
              bzero_q  <= (bus.B == '0);
              a_q      <= bus.A;
              mb_q     <= mag_b;
              acc_q    <= '0;
              lo_q     <= mag_a;
            end else begin
              result_q <= alu_d;
              zero_q   <= (alu_d == '0);
              ovf_q    <= ovf_d;
              divz_q   <= 1'b0;
              done_q   <= 1'b1;
            end
          end
        end
        S_RUN: begin
          acc_q <= acc_nx;
          lo_q  <= lo_nx;
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == '0) begin
            state_q  <= S_FIN;
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
            result_q <= fin_res;
            hi_q     <= fin_hi;
            zero_q   <= (fin_res == '0);
            ovf_q    <= 1'b0;
            divz_q   <= fin_divz;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.Busy      = busy_q;
  assign bus.Done      = done_q;
  assign bus.ALUResult = result_q;
  assign bus.Hi        = hi_q;
  assign bus.Zero      = zero_q;
  assign bus.Overflow  = ovf_q;
  assign bus.DivZero   = divz_q;
  assign bus.dbg_state = state_q;
endmodule
